// File: rtl/tape_player.sv
// rtl/tape_player.sv - cassette playback square-wave generator for MGF_IN (optional parity: TAPE_PARITY_EN)
module tape_player #(
  parameter int unsigned PILOT_HALF  = 3000,
  parameter int unsigned PILOT_COUNT = 2000,
  parameter int unsigned SYNC_HALF   = 800,
  parameter int unsigned ZERO_HALF   = 1200,
  parameter int unsigned ONE_HALF    = 2400
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       mgf_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  // Counter reload values are H-1 so a half-period lasts exactly H cycles.
  localparam logic [15:0] PILOT_LD   = 16'(PILOT_HALF - 1);
  localparam logic [15:0] PILOT_LAST = 16'(PILOT_COUNT - 1);
  localparam logic [15:0] SYNC_LD    = 16'(SYNC_HALF - 1);
  localparam logic [15:0] ZERO_LD    = 16'(ZERO_HALF - 1);
  localparam logic [15:0] ONE_LD     = 16'(ONE_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, PILOT, SYNC, LOAD, BITS,
`ifdef TAPE_PARITY_EN
    PAR,
`endif
    TRAIL, DONE
  } state_t;

  state_t      state, state_n;
  logic        phase, phase_n;        // 0: high half, 1: low half
  logic [15:0] cnt, cnt_n;
  logic [15:0] sym_cnt, sym_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        last_q, last_n;
  logic        under_q, under_n;
`ifdef TAPE_PARITY_EN
  logic        par_q, par_n;
`endif

  function automatic logic [15:0] bit_load(input logic b);
    return b ? ONE_LD : ZERO_LD;
  endfunction

  assign underrun = under_q;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 1'b0;
      cnt     <= '0;
      sym_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
      under_q <= 1'b0;
`ifdef TAPE_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      cnt     <= cnt_n;
      sym_cnt <= sym_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      last_q  <= last_n;
      under_q <= under_n;
`ifdef TAPE_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // Next-state, symbol timing and output decode.
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    sym_n   = sym_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    last_n  = last_q;
    under_n = under_q;
`ifdef TAPE_PARITY_EN
    par_n   = par_q;
`endif
    mgf_out = 1'b0;
    s_ready = 1'b0;
    done    = 1'b0;
    busy    = (state != IDLE) && (state != DONE);

    case (state)
      IDLE: begin
        if (start) begin
          state_n = PILOT;
          phase_n = 1'b0;
          cnt_n   = PILOT_LD;
          sym_n   = '0;
          under_n = 1'b0;
        end
      end
      PILOT: begin
        mgf_out = ~phase;
        if (cnt != 16'd0) cnt_n = cnt - 16'd1;
        else if (!phase) begin
          phase_n = 1'b1;
          cnt_n   = PILOT_LD;
        end else if (sym_cnt == PILOT_LAST) begin
          state_n = SYNC;
          phase_n = 1'b0;
          cnt_n   = SYNC_LD;
        end else begin
          sym_n   = sym_cnt + 16'd1;
          phase_n = 1'b0;
          cnt_n   = PILOT_LD;
        end
      end
      SYNC: begin
        mgf_out = ~phase;
        if (cnt != 16'd0) cnt_n = cnt - 16'd1;
        else if (!phase) begin
          phase_n = 1'b1;
          cnt_n   = SYNC_LD;
        end else begin
          state_n = LOAD;
          phase_n = 1'b0;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_n = BITS;
          shreg_n = s_data;
          last_n  = s_last;
          bit_n   = '0;
          phase_n = 1'b0;
          cnt_n   = bit_load(s_data[7]);
`ifdef TAPE_PARITY_EN
          par_n   = ~^s_data;
`endif
        end else begin
          under_n = 1'b1;
        end
      end
      BITS: begin
        mgf_out = ~phase;
        if (cnt != 16'd0) cnt_n = cnt - 16'd1;
        else if (!phase) begin
          phase_n = 1'b1;
          cnt_n   = bit_load(shreg[7]);
        end else if (bit_cnt != 3'd7) begin
          bit_n   = bit_cnt + 3'd1;
          shreg_n = {shreg[6:0], 1'b0};
          phase_n = 1'b0;
          cnt_n   = bit_load(shreg[6]);
        end else begin
          phase_n = 1'b0;
`ifdef TAPE_PARITY_EN
          state_n = PAR;
          cnt_n   = bit_load(par_q);
`else
          state_n = last_q ? TRAIL : LOAD;
          cnt_n   = last_q ? SYNC_LD : 16'd0;
`endif
        end
      end
`ifdef TAPE_PARITY_EN
      PAR: begin
        mgf_out = ~phase;
        if (cnt != 16'd0) cnt_n = cnt - 16'd1;
        else if (!phase) begin
          phase_n = 1'b1;
          cnt_n   = bit_load(par_q);
        end else begin
          phase_n = 1'b0;
          state_n = last_q ? TRAIL : LOAD;
          cnt_n   = last_q ? SYNC_LD : 16'd0;
        end
      end
`endif
      TRAIL: begin
        mgf_out = ~phase;
        if (cnt != 16'd0) cnt_n = cnt - 16'd1;
        else if (!phase) begin
          phase_n = 1'b1;
          cnt_n   = SYNC_LD;
        end else begin
          state_n = DONE;
          phase_n = 1'b0;
          cnt_n   = '0;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Abort drops back to idle next cycle but keeps the starvation flag.
    if (abort) begin
      state_n = IDLE;
      phase_n = 1'b0;
      cnt_n   = '0;
      under_n = under_q;
    end
  end

endmodule

// File: tb/tb_tape_player.sv
// tb/tb_tape_player.sv - self-checking bench for tape_player (optional parity: TAPE_PARITY_EN)
module tb_tape_player;

  localparam int PH = 4, PC = 2, SH = 2, ZH = 3, OH = 6;
`ifdef TAPE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int PX = PAR_EN ? 12 : 0;  // extra cycles of a parity symbol with H=6

  logic       clk_sys = 1'b0;
  logic       reset, start, abort;
  logic [7:0] s_data;
  logic       s_valid, s_last;
  logic       s_ready, mgf_out, busy, done, underrun;

  tape_player #(
    .PILOT_HALF(PH), .PILOT_COUNT(PC), .SYNC_HALF(SH), .ZERO_HALF(ZH), .ONE_HALF(OH)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .mgf_out(mgf_out), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Expected per-cycle vector: {mgf_out, s_ready, busy, done, underrun}
  logic [4:0] expq[$];
  logic [4:0] hold;
  logic [4:0] hist[0:1023];
  logic [7:0] feed[$];
  int         fidx;
  bit         hs_prev;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_sym(input int h);
    repeat (h) expq.push_back(5'b10100);
    repeat (h) expq.push_back(5'b00100);
  endtask

  // Whole-block waveform from the symbol list: pilot, sync, bytes, trailer, done.
  task automatic build();
    repeat (PC) push_sym(PH);
    push_sym(SH);
    foreach (feed[i]) begin
      expq.push_back(5'b01100);
      for (int k = 7; k >= 0; k--) push_sym(feed[i][k] ? OH : ZH);
      if (PAR_EN) push_sym(($countones(feed[i]) % 2 == 0) ? OH : ZH);
    end
    push_sym(SH);
    expq.push_back(5'b00010);
  endtask

  task automatic do_cycle();
    logic [4:0] act, exp;
    @(negedge clk_sys);
    cyc++;
    act = {mgf_out, s_ready, busy, done, underrun};
    if (cyc < 1024) hist[cyc] = act;
    exp = (expq.size() > 0) ? expq.pop_front() : hold;
    check($sformatf("cycle%0d", cyc), act, exp);
    if (hs_prev) fidx++;
    if (fidx < feed.size()) begin
      s_valid = 1'b1;
      s_data  = feed[fidx];
      s_last  = (fidx == feed.size() - 1);
    end else begin
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
    end
    hs_prev = s_valid && s_ready;
  endtask

  task automatic start_block();
    fidx = 0;
    hs_prev = 1'b0;
    for (int i = 0; i < 1024; i++) hist[i] = 5'b0;
    start = 1'b1;
    @(posedge clk_sys);
    #1 start = 1'b0;
    cyc = 0;
  endtask

  task automatic drain(input int extra);
    int g = 0;
    while (expq.size() > 0 && g < 4000) begin
      do_cycle();
      g++;
    end
    if (expq.size() > 0) check("drain_timeout", expq.size(), 0);
    repeat (extra) do_cycle();
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    for (int i = 1; i < 1024; i++) if (hist[i][b]) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    fidx = 0; hs_prev = 1'b0; hold = 5'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    do_cycle();
    check("reset_outputs", {mgf_out, s_ready, busy, done, underrun}, 0);

    // Starved stream: pilot and sync, then wait in LOAD with underrun.
    feed.delete();
    repeat (PC) push_sym(PH);
    push_sym(SH);
    expq.push_back(5'b01100);
    hold = 5'b01101;
    start_block();
    repeat (30) do_cycle();
    check("s1_mgf1", hist[1][4], 1);
    check("s1_busy1", hist[1][2], 1);
    check("s1_mgf4", hist[4][4], 1);
    check("s1_mgf5", hist[5][4], 0);
    check("s1_mgf9", hist[9][4], 1);
    check("s1_mgf18", hist[18][4], 1);
    check("s1_mgf19", hist[19][4], 0);
    check("s1_rdy20", hist[20][3], 0);
    check("s1_rdy21", hist[21][3], 1);
    check("s1_und21", hist[21][0], 0);
    check("s1_und22", hist[22][0], 1);
    // Abort out of LOAD keeps underrun.
    abort = 1'b1; expq.delete(); hold = 5'b00001;
    @(posedge clk_sys);
    #1 abort = 1'b0;
    repeat (3) do_cycle();

    // Single byte 0xA0; start clears underrun.
    feed = '{8'hA0};
    hold = 5'b0;
    build();
    start_block();
    drain(5);
    check("s2_mgf27", hist[27][4], 1);
    check("s2_mgf28", hist[28][4], 0);
    check("s2_mgf34", hist[34][4], 1);
    check("s2_mgf36", hist[36][4], 1);
    check("s2_mgf37", hist[37][4], 0);
    check("s2_done_pre", hist[85 + PX][1], 0);
    check("s2_done", hist[86 + PX][1], 1);
    check("s2_busy_after", hist[87 + PX][2], 0);
    check("s2_done_count", count_bit(1), 1);

    // Back-to-back 0xFF, 0x00.
    feed = '{8'hFF, 8'h00};
    build();
    start_block();
    drain(3);
    check("s3_rdy117", hist[117 + PX][3], 0);
    check("s3_rdy118", hist[118 + PX][3], 1);
    check("s3_mgf118", hist[118 + PX][4], 0);
    check("s3_mgf119", hist[119 + PX][4], 1);
    check("s3_mgf121", hist[121 + PX][4], 1);
    check("s3_mgf122", hist[122 + PX][4], 0);
    check("s3_rdy_count", count_bit(3), 2);

    // Abort mid-BITS, then replay from pilot.
    feed = '{8'h55};
    build();
    start_block();
    repeat (30) do_cycle();
    abort = 1'b1; expq.delete(); hold = 5'b0;
    @(posedge clk_sys);
    #1 abort = 1'b0;
    repeat (10) do_cycle();
    check("s4_busy31", hist[31][2], 0);
    check("s4_mgf31", hist[31][4], 0);
    check("s4_no_done", count_bit(1), 0);
    build();
    start_block();
    drain(3);
    check("s4_replay_done", count_bit(1), 1);

    // Abort and start together in idle.
    abort = 1'b1; start = 1'b1;
    @(posedge clk_sys);
    #1 begin abort = 1'b0; start = 1'b0; end
    repeat (5) do_cycle();

    // Start pulse during BITS is ignored.
    feed = '{8'hC3};
    build();
    start_block();
    repeat (40) do_cycle();
    start = 1'b1;
    @(posedge clk_sys);
    #1 start = 1'b0;
    drain(3);
    check("s6_done_count", count_bit(1), 1);

    // Reset mid-block abandons without done.
    feed = '{8'h12};
    build();
    start_block();
    repeat (10) do_cycle();
    reset = 1'b1; expq.delete(); hold = 5'b0;
    @(posedge clk_sys);
    #1 reset = 1'b0;
    repeat (5) do_cycle();
    check("s7_no_done", count_bit(1), 0);

    // Bytes 0x03, 0x07: parity symbols when enabled.
    feed = '{8'h03, 8'h07};
    build();
    start_block();
    drain(3);
`ifdef TAPE_PARITY_EN
    check("s8_par03_hi", hist[87][4], 1);
    check("s8_par03_lo", hist[88][4], 0);
    check("s8_rdy94", hist[94][3], 1);
    check("s8_par07_hi", hist[163][4], 1);
    check("s8_par07_lo", hist[164][4], 0);
`else
    check("s8_mgf81", hist[81][4], 0);
    check("s8_rdy82", hist[82][3], 1);
    check("s8_mgf83", hist[83][4], 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
